// File: rtl/audio_mix_pkg.sv
// Shared types and arithmetic helpers for the audio mixer and its sigma-delta DAC.
package audio_mix_pkg;

  // Per-channel gain code as it arrives on ch_gain_i.
  typedef enum logic [1:0] {
    MUTE = 2'd0,
    Q    = 2'd1,
    H    = 2'd2,
    F    = 2'd3
  } gain_e;

  // Clamp a signed value to the range of a signed number 'width' bits wide.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                    input int                 width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end else begin
      return value;
    end
  endfunction

  // Scale a signed sample by 0, 1/4, 1/2 or 1 using arithmetic right shifts.
  function automatic logic signed [31:0] apply_gain(input logic signed [31:0] sample,
                                                    input gain_e              gain);
    case (gain)
      MUTE:    return 32'sd0;
      Q:       return sample >>> 2;
      H:       return sample >>> 1;
      F:       return sample;
      default: return 32'sd0;
    endcase
  endfunction

endpackage

// File: rtl/audio_mixer_sd_if.sv
// Sample-side bus of the mixer: channel inputs with capture strobe, mixed output with valid.
interface audio_mixer_sd_if #(
  parameter int NCH   = 4,
  parameter int IN_W  = 14,
  parameter int OUT_W = 16
);
  logic                   sample_stb_i;
  logic [NCH*IN_W-1:0]    ch_data_i;
  logic [NCH-1:0]         ch_signed_i;
  logic [2*NCH-1:0]       ch_gain_i;
  logic [OUT_W-1:0]       mix_o;
  logic                   mix_valid_o;

  modport master (
    output sample_stb_i, ch_data_i, ch_signed_i, ch_gain_i,
    input  mix_o, mix_valid_o
  );

  modport slave (
    input  sample_stb_i, ch_data_i, ch_signed_i, ch_gain_i,
    output mix_o, mix_valid_o
  );
endinterface

// File: rtl/sd_dac.sv
// Sigma-delta bitstream DAC, first or second order, driven by a signed left-aligned sample.
module sd_dac
  import audio_mix_pkg::*;
#(
  parameter int W     = 16,
  parameter int ORDER = 1
) (
  input  logic         clk_i,
  input  logic         res_n_i,
  input  logic [W-1:0] din_i,
  output logic         dout_o
);

  if (ORDER == 2) begin : g_o2
    localparam int IW = W + 4;
    localparam logic signed [31:0] FB_MAG = 32'sd1 <<< (W - 1);

    logic signed [IW-1:0] r_i1;
    logic signed [IW-1:0] r_i2;
    logic                 r_dout;
    logic signed [31:0]   w_s;
    logic signed [31:0]   w_fb;
    logic signed [IW-1:0] w_i1_n;
    logic signed [IW-1:0] w_i2_n;

    assign w_s  = 32'($signed(din_i));
    assign w_fb = r_dout ? FB_MAG : -FB_MAG;
    // The second integrator takes the freshly updated first integrator so the loop
    // has the classic (1 - z^-1)^2 noise shaping and stays stable with a 1-bit quantiser.
    assign w_i1_n = IW'(sat_signed(32'(r_i1) + w_s - w_fb, IW));
    assign w_i2_n = IW'(sat_signed(32'(r_i2) + 32'(w_i1_n) - w_fb, IW));

    // Integrator and quantiser state, one update per clock.
    always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
        r_i1   <= '0;
        r_i2   <= '0;
        r_dout <= 1'b0;
      end else begin
        r_i1   <= w_i1_n;
        r_i2   <= w_i2_n;
        r_dout <= ~w_i2_n[IW-1];
      end
    end

    assign dout_o = r_dout;
  end else begin : g_o1
    // Bit W of the accumulator is the carry of the latest addition and doubles as the output.
    logic [W:0]   r_acc;
    logic [W-1:0] w_u;

    assign w_u = {~din_i[W-1], din_i[W-2:0]};

    // Phase accumulator: the carry out is the bitstream.
    always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
        r_acc <= '0;
      end else begin
        r_acc <= {1'b0, r_acc[W-1:0]} + {1'b0, w_u};
      end
    end

    assign dout_o = r_acc[W];
  end

endmodule

// File: rtl/audio_mixer_sd.sv
// N-channel mixer: capture/convert/gain (S1), sum (S2), saturate and align (S3),
// followed by a sigma-delta DAC running on the held mixed sample.
module audio_mixer_sd
  import audio_mix_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int IN_W  = 14,
  parameter int OUT_W = 16,
  parameter int ORDER = 1
) (
  input  logic             clk_i,
  input  logic             res_n_i,
  audio_mixer_sd_if.slave  mix_bus,
  output logic             dac_o
);

  // Sum of NCH IN_W-bit values cannot overflow this width.
  localparam int SUM_W = IN_W + $clog2(NCH) + 1;

  logic [NCH*IN_W-1:0]     w_gained_all;
  logic [NCH*IN_W-1:0]     r_s1_data;
  logic                    r_s1_vld;
  logic signed [SUM_W-1:0] w_sum;
  logic signed [SUM_W-1:0] r_s2_sum;
  logic                    r_s2_vld;
  logic [IN_W-1:0]         w_sat;
  logic [OUT_W-1:0]        w_mix_next;
  logic [OUT_W-1:0]        r_mix;
  logic                    r_mix_vld;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [IN_W-1:0]    w_conv;
    logic signed [31:0] w_ext;

    // Offset-binary becomes two's complement by flipping the MSB.
    assign w_conv = {mix_bus.ch_data_i[k*IN_W + IN_W - 1] ^ ~mix_bus.ch_signed_i[k],
                     mix_bus.ch_data_i[k*IN_W +: IN_W - 1]};
    assign w_ext  = 32'($signed(w_conv));
    assign w_gained_all[k*IN_W +: IN_W] =
        IN_W'(apply_gain(w_ext, gain_e'(mix_bus.ch_gain_i[2*k +: 2])));
  end

  // S1: capture the converted and scaled channels on each strobe.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_s1_data <= '0;
      r_s1_vld  <= 1'b0;
    end else begin
      r_s1_vld <= mix_bus.sample_stb_i;
      if (mix_bus.sample_stb_i) begin
        r_s1_data <= w_gained_all;
      end else begin
        r_s1_data <= r_s1_data;
      end
    end
  end

  // Full-width signed sum of all captured channels.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NCH; i++) begin
      w_sum = w_sum + SUM_W'($signed(r_s1_data[i*IN_W +: IN_W]));
    end
  end

  // S2: register the sum.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_s2_sum <= '0;
      r_s2_vld <= 1'b0;
    end else begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_sum <= w_sum;
      end else begin
        r_s2_sum <= r_s2_sum;
      end
    end
  end

  assign w_sat      = IN_W'(sat_signed(32'(r_s2_sum), IN_W));
  assign w_mix_next = OUT_W'(w_sat) << (OUT_W - IN_W);

  // S3: saturate, left-align into mix_o and pulse valid; mix_o holds otherwise.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_mix     <= '0;
      r_mix_vld <= 1'b0;
    end else begin
      r_mix_vld <= r_s2_vld;
      if (r_s2_vld) begin
        r_mix <= w_mix_next;
      end else begin
        r_mix <= r_mix;
      end
    end
  end

  assign mix_bus.mix_o       = r_mix;
  assign mix_bus.mix_valid_o = r_mix_vld;

  sd_dac #(
    .W     (OUT_W),
    .ORDER (ORDER)
  ) u_dac (
    .clk_i   (clk_i),
    .res_n_i (res_n_i),
    .din_i   (r_mix),
    .dout_o  (dac_o)
  );

endmodule

// File: tb/tb_audio_mixer_sd.sv
// Directed plus randomized bench for audio_mixer_sd: one first-order and one
// second-order instance receive identical channel stimulus.
module tb_audio_mixer_sd;

  localparam int NCH   = 4;
  localparam int IN_W  = 14;
  localparam int OUT_W = 16;

  logic clk   = 1'b0;
  logic res_n = 1'b1;
  logic dac1;
  logic dac2;
  int   checks = 0;
  int   errors = 0;

  audio_mixer_sd_if #(.NCH(NCH), .IN_W(IN_W), .OUT_W(OUT_W)) bus1 ();
  audio_mixer_sd_if #(.NCH(NCH), .IN_W(IN_W), .OUT_W(OUT_W)) bus2 ();

  audio_mixer_sd #(.NCH(NCH), .IN_W(IN_W), .OUT_W(OUT_W), .ORDER(1)) dut1 (
    .clk_i   (clk),
    .res_n_i (res_n),
    .mix_bus (bus1),
    .dac_o   (dac1)
  );

  audio_mixer_sd #(.NCH(NCH), .IN_W(IN_W), .OUT_W(OUT_W), .ORDER(2)) dut2 (
    .clk_i   (clk),
    .res_n_i (res_n),
    .mix_bus (bus2),
    .dac_o   (dac2)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic drive(input logic stb, input logic [NCH*IN_W-1:0] d,
                       input logic [NCH-1:0] s, input logic [2*NCH-1:0] g);
    bus1.sample_stb_i = stb;  bus2.sample_stb_i = stb;
    bus1.ch_data_i    = d;    bus2.ch_data_i    = d;
    bus1.ch_signed_i  = s;    bus2.ch_signed_i  = s;
    bus1.ch_gain_i    = g;    bus2.ch_gain_i    = g;
  endtask

  // Reference: integer arithmetic straight from the channel format and gain rules.
  function automatic logic [OUT_W-1:0] model_mix(input logic [NCH*IN_W-1:0] d,
                                                 input logic [NCH-1:0] s,
                                                 input logic [2*NCH-1:0] g);
    int acc = 0;
    for (int ch = 0; ch < NCH; ch++) begin
      int raw = int'(d[ch*IN_W +: IN_W]);
      int v;
      int gcode = int'(g[2*ch +: 2]);
      if (s[ch]) v = (raw >= (1 << (IN_W - 1))) ? raw - (1 << IN_W) : raw;
      else       v = raw - (1 << (IN_W - 1));
      if (gcode == 0)      v = 0;
      else if (gcode == 1) v = v >>> 2;
      else if (gcode == 2) v = v >>> 1;
      acc += v;
    end
    if (acc > (1 << (IN_W - 1)) - 1) acc = (1 << (IN_W - 1)) - 1;
    if (acc < -(1 << (IN_W - 1)))    acc = -(1 << (IN_W - 1));
    return OUT_W'(acc * (1 << (OUT_W - IN_W)));
  endfunction

  // One strobe; checks latency, single-cycle pulse, value on both instances, and hold.
  task automatic send_check(input string tag, input logic [NCH*IN_W-1:0] d,
                            input logic [NCH-1:0] s, input logic [2*NCH-1:0] g,
                            input logic [OUT_W-1:0] exp);
    @(posedge clk); #1 drive(1'b1, d, s, g);
    @(posedge clk); #1 drive(1'b0, d, s, g);
    @(negedge clk); chk({tag, "/vld_n+1"}, 32'(bus1.mix_valid_o), 32'd0);
    @(negedge clk); chk({tag, "/vld_n+2"}, 32'(bus1.mix_valid_o), 32'd0);
    @(negedge clk);
    chk({tag, "/vld_n+3"}, 32'(bus1.mix_valid_o), 32'd1);
    chk({tag, "/mix1"},    32'(bus1.mix_o), 32'(exp));
    chk({tag, "/mix2"},    32'(bus2.mix_o), 32'(exp));
    @(negedge clk);
    chk({tag, "/vld_n+4"}, 32'(bus1.mix_valid_o), 32'd0);
    chk({tag, "/hold"},    32'(bus1.mix_o), 32'(exp));
  endtask

  initial begin
    logic [NCH*IN_W-1:0] d;
    logic [NCH-1:0]      s;
    logic [2*NCH-1:0]    g;
    int pulses;
    int ones1;
    int ones2;

    drive(1'b0, '0, '0, '0);
    #2 res_n = 1'b0;
    #1;
    chk("rst/mix1", 32'(bus1.mix_o), 32'd0);
    chk("rst/vld1", 32'(bus1.mix_valid_o), 32'd0);
    chk("rst/dac1", 32'(dac1), 32'd0);
    chk("rst/mix2", 32'(bus2.mix_o), 32'd0);
    chk("rst/dac2", 32'(dac2), 32'd0);
    // Strobe while held in reset must be ignored.
    drive(1'b1, {NCH{14'h1FFF}}, 4'hF, 8'hFF);
    repeat (3) @(posedge clk);
    #1 drive(1'b0, '0, '0, '0);
    @(posedge clk); #1 res_n = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      pulses += int'(bus1.mix_valid_o) + int'(bus2.mix_valid_o);
    end
    chk("rst/no_pulse", 32'(pulses), 32'd0);
    chk("rst/mix_after", 32'(bus1.mix_o), 32'd0);

    // Single channel at unity gain.
    send_check("t1", 56'h0400, 4'b0001, 8'b0000_0011, 16'h1000);
    // Positive and negative saturation.
    send_check("t2_pos", {NCH{14'h1FFF}}, 4'hF, 8'hFF, 16'h7FFC);
    send_check("t2_neg", {NCH{14'h2000}}, 4'hF, 8'hFF, 16'h8000);
    // Offset-binary channel at half gain, then muted.
    d = '0;
    d[27:14] = 14'h3FFF;
    send_check("t3_half", d, 4'b0000, 8'b0000_1000, 16'h3FFC);
    send_check("t3_mute", d, 4'b0000, 8'b0000_0000, 16'h0000);

    // Three strobes on consecutive cycles.
    @(posedge clk); #1 drive(1'b1, 56'h10, 4'b0001, 8'b0000_0011);
    @(posedge clk); #1 drive(1'b1, 56'h20, 4'b0001, 8'b0000_0011);
    @(posedge clk); #1 drive(1'b1, 56'h30, 4'b0001, 8'b0000_0011);
    @(posedge clk); #1 drive(1'b0, 56'h30, 4'b0001, 8'b0000_0011);
    @(negedge clk);
    chk("t4/vld0", 32'(bus1.mix_valid_o), 32'd1);
    chk("t4/mix0", 32'(bus1.mix_o), 32'h40);
    @(negedge clk);
    chk("t4/vld1", 32'(bus1.mix_valid_o), 32'd1);
    chk("t4/mix1", 32'(bus1.mix_o), 32'h80);
    @(negedge clk);
    chk("t4/vld2", 32'(bus1.mix_valid_o), 32'd1);
    chk("t4/mix2", 32'(bus1.mix_o), 32'hC0);
    @(negedge clk);
    chk("t4/vld3", 32'(bus1.mix_valid_o), 32'd0);

    // Random formats, gains and data against the reference model.
    for (int n = 0; n < 24; n++) begin
      d = (NCH*IN_W)'({$urandom(), $urandom()});
      s = NCH'($urandom());
      g = (2*NCH)'($urandom());
      send_check($sformatf("rnd%0d", n), d, s, g, model_mix(d, s, g));
    end

    // DAC duty with mix_o held at 0x4000: mean ones = 0.75 * clocks.
    send_check("t5_set", 56'h1000, 4'b0001, 8'b0000_0011, 16'h4000);
    repeat (4) @(negedge clk);
    ones1 = 0;
    ones2 = 0;
    for (int c = 0; c < 65536; c++) begin
      @(negedge clk);
      ones1 += int'(dac1);
      ones2 += int'(dac2);
    end
    chk_range("t5/ord1_ones", ones1, (65536 * 3 / 4) - 1, (65536 * 3 / 4) + 1);
    chk_range("t5/ord2_ones", ones2, (65536 * 3 / 4) - 16, (65536 * 3 / 4) + 16);

    // Reset one cycle after a strobe: outputs clear, in-flight sample is dropped.
    @(posedge clk); #1 drive(1'b1, 56'h0400, 4'b0001, 8'b0000_0011);
    @(posedge clk); #1 drive(1'b0, 56'h0400, 4'b0001, 8'b0000_0011);
    res_n = 1'b0;
    #1;
    chk("t6/mix1", 32'(bus1.mix_o), 32'd0);
    chk("t6/vld1", 32'(bus1.mix_valid_o), 32'd0);
    chk("t6/dac1", 32'(dac1), 32'd0);
    chk("t6/mix2", 32'(bus2.mix_o), 32'd0);
    chk("t6/dac2", 32'(dac2), 32'd0);
    @(posedge clk);
    @(posedge clk); #1 res_n = 1'b1;
    pulses = 0;
    ones1 = 0;
    for (int c = 0; c < 1024; c++) begin
      @(negedge clk);
      pulses += int'(bus1.mix_valid_o) + int'(bus2.mix_valid_o);
      ones1  += int'(dac1);
    end
    chk("t6/no_pulse", 32'(pulses), 32'd0);
    chk_range("t6/ord1_half", ones1, 511, 513);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
